// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op_t     : EX-stage operation encodings for HI/LO-writing instructions
//   - state_t  : sequencer states
//   - ITERS_DEFAULT : iterations per multiply/divide (operand width)
//   - mag()    : two's-complement magnitude helper for signed operands
package hilo_pkg;

    localparam int ITERS_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    // Magnitude of v when it is treated as signed; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single-iteration engine shared by multiply and divide.
//   is_div  in  1   select restoring-divide step (1) or shift/add multiply step (0)
//   acc     in  32  multiply: high product half; divide: partial remainder
//   q       in  32  multiply: multiplier / low product bits; divide: dividend / quotient bits
//   m       in  32  multiplicand or divisor magnitude
//   acc_nxt out 32  accumulator after this iteration
//   q_nxt   out 32  shift register after this iteration
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] q,
    input  logic [31:0] m,
    output logic [31:0] acc_nxt,
    output logic [31:0] q_nxt
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
        // Remainder shifted left with the next dividend bit; may need 33 bits.
        shifted = {acc, q[31]};
        diff    = {1'b0, shifted} - {2'b00, m};
        acc_nxt = sum[32:1];
        q_nxt   = {sum[0], q[31:1]};
        if (is_div) begin
            // A successful trial subtract always leaves diff < m, so both top
            // bits are zero exactly when the subtraction did not borrow.
            if (diff[33:32] == 2'b00) begin
                acc_nxt = diff[31:0];
                q_nxt   = {q[30:0], 1'b1};
            end else begin
                acc_nxt = shifted[31:0];
                q_nxt   = {q[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative multiply/divide sequencer and owner of HI/LO.
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   op_valid   in   1   EX holds a HI/LO-writing instruction
//   op         in   3   op_t encoding (0 and 7 are no-ops)
//   a, b       in   32  rs / rt operands
//   read_hilo  in   1   EX holds MFHI/MFLO
//   stall      out  1   freeze front of pipeline (combinational)
//   busy       out  1   multiply/divide in progress
//   rhi, rlo   out  32  architectural HI / LO
//   dbg_state  out  2   current sequencer state (state_t)
//
// Handshake: op_valid is the request, ~stall is the ready. An op is taken on
// a rising edge where op_valid=1 and busy=0; while busy, the requester must
// hold op/a/b steady and stall stays high, so the op is taken on the first
// edge after the commit edge. read_hilo is held off the same way.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        read_hilo,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rhi,
    output logic [31:0] rlo,
    output logic [1:0]  dbg_state
);

    localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] acc, q, m, a_raw;
    logic        neg_q, neg_r, div_zero;

    logic        accept, is_mul_op, is_div_op, signed_op, last;
    logic [31:0] acc_s, q_s;
    logic [63:0] prod;
    logic [31:0] quo, rem, commit_hi, commit_lo;

    assign busy      = (state != IDLE);
    assign stall     = busy & (op_valid | read_hilo);
    assign dbg_state = state;

    assign accept    = op_valid && (state == IDLE) && (op != OP_NONE) && (op != 3'd7);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign last      = (cnt == LAST_CNT);

    muldiv_step u_step (
        .is_div  (state == DIV),
        .acc     (acc),
        .q       (q),
        .m       (m),
        .acc_nxt (acc_s),
        .q_nxt   (q_s)
    );

    // Result of the final iteration with sign fix-up applied, written at commit.
    always_comb begin
        prod = {acc_s, q_s};
        if (neg_q) prod = -prod;
        quo  = neg_q ? -q_s : q_s;
        rem  = neg_r ? -acc_s : acc_s;
        if (state == MUL) begin
            commit_hi = prod[63:32];
            commit_lo = prod[31:0];
        end else if (div_zero) begin
            commit_hi = a_raw;
            commit_lo = 32'hFFFF_FFFF;
        end else begin
            commit_hi = rem;
            commit_lo = quo;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mul_op)      state_nxt = MUL;
                else if (accept && is_div_op) state_nxt = DIV;
            end
            MUL, DIV: begin
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            rhi      <= '0;
            rlo      <= '0;
        end else if (accept) begin
            cnt      <= '0;
            acc      <= '0;
            a_raw    <= a;
            neg_q    <= signed_op & (a[31] ^ b[31]);
            neg_r    <= signed_op & a[31];
            div_zero <= (b == 32'd0);
            if (is_mul_op) begin
                m <= mag(a, signed_op);
                q <= mag(b, signed_op);
            end else if (is_div_op) begin
                q <= mag(a, signed_op);
                m <= mag(b, signed_op);
            end
            if (op == OP_MTHI) rhi <= a;
            if (op == OP_MTLO) rlo <= a;
        end else if (busy) begin
            acc <= acc_s;
            q   <= q_s;
            if (last) begin
                rhi <= commit_hi;
                rlo <= commit_lo;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        read_hilo = 1'b0;
    logic        stall, busy;
    logic [31:0] rhi, rlo;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .read_hilo (read_hilo),
        .stall     (stall),
        .busy      (busy),
        .rhi       (rhi),
        .rlo       (rlo),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_commit = 0;
    logic        prev_busy = 1'b0;
    logic [63:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition outside reset is a commit; pop and compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                n_commit++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL commit%0d: got %h, expected no commit", n_commit, {rhi, rlo});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check($sformatf("commit%0d", n_commit), {rhi, rlo}, mon_exp);
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    // Called 1 time unit after a rising edge; the op is taken on the next edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        op_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    // ---------------- directed vectors ----------------
    localparam int NV = 10;
    logic [2:0]  v_op [NV] = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd3, 3'd1, 3'd3, 3'd2};
    logic [31:0] v_a  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100,
                               32'h80000000, 32'hFFFFFFFB, 32'd7, 32'd100, 32'h00010000};
    logic [31:0] v_b  [NV] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7,
                               32'hFFFFFFFF, 32'd0, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h00010000};
    logic [63:0] v_exp[NV] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD,
                               64'h00000007_FFFFFFFF, 64'h00000000_80000000,
                               64'h00000002_0000000E, 64'h00000000_80000000,
                               64'hFFFFFFFB_FFFFFFFF, 64'hFFFFFFFF_FFFFFFD6,
                               64'h00000002_FFFFFFF2, 64'h00000001_00000000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;

        // Reset state: stall must stay low even with requests present.
        op_valid  = 1'b1;
        op        = OP_MULT;
        read_hilo = 1'b1;
        #3;
        check("reset_hilo",  {rhi, rlo}, 64'd0);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        op_valid  = 1'b0;
        op        = 3'd0;
        read_hilo = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULT -3 * 5, with busy width measured.
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        check("mult_state", 64'(dbg_state), 64'd1);
        k = 0;
        while (busy && k < 100) begin
            k++;
            @(posedge clk);
            #1;
        end
        check("mult_busy_cycles", 64'(k), 64'd32);

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(v_exp[i]);
            issue(v_op[i], v_a[i], v_b[i]);
            wait_idle($sformatf("vec%0d", i));
        end

        // MFHI held across a multiply.
        exp_q.push_back(64'h00000000_0000002A);
        issue(OP_MULT, 32'd6, 32'd7);
        read_hilo = 1'b1;
        k = 0;
        while (stall && k < 100) begin
            k++;
            @(posedge clk);
            #1;
        end
        check("mf_stall_cycles", 64'(k), 64'd32);
        check("mf_read_value", {rhi, rlo}, 64'h00000000_0000002A);
        read_hilo = 1'b0;

        // MTLO requested while busy: held, then overwrites the MULT LO.
        exp_q.push_back(64'h00000000_00000006);
        issue(OP_MULT, 32'd2, 32'd3);
        op_valid = 1'b1;
        op       = OP_MTLO;
        a        = 32'h1234;
        k   = 0;
        bad = 0;
        while (stall && k < 100) begin
            if (rlo !== 32'h2A) bad++;
            k++;
            @(posedge clk);
            #1;
        end
        check("mtlo_stall_cycles", 64'(k), 64'd32);
        check("mtlo_rlo_held", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
        a        = '0;
        check("mtlo_after", {rhi, rlo}, 64'h00000000_00001234);
        check("mtlo_busy", 64'(busy), 64'd0);

        // MTHI then MFHI back-to-back: no stall, new value visible.
        issue(OP_MTHI, 32'h0000BEEF, 32'd0);
        read_hilo = 1'b1;
        check("mthi_mfhi_stall", 64'(stall), 64'd0);
        check("mthi_value", 64'(rhi), 64'h0000BEEF);
        read_hilo = 1'b0;

        // Reset in the middle of a divide (between E10 and E11).
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_hilo",  {rhi, rlo}, 64'd0);
        check("rst_mid_busy",  64'(busy), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue(OP_MTHI, 32'h000000A5, 32'd0);
        check("post_rst_mthi", {rhi, rlo}, 64'h000000A5_00000000);
        check("post_rst_busy", 64'(busy), 64'd0);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
